// File: rtl/poly_eval_seq.sv
// poly_eval_seq: Horner-rule polynomial evaluator, one MAC per clock.
// Ports: ck, rst (async low), inicio, X, coef -> busy, pronto, overflow, resultado.
// POLY_EVAL_SAT_EN: clamp out-of-range steps instead of wrapping.
module poly_eval_seq #(
  parameter int WIDTH  = 16,
  parameter int DEGREE = 2,
  parameter int SIGNED = 0
) (
  input  logic                        ck,
  input  logic                        rst,
  input  logic                        inicio,
  input  logic [WIDTH-1:0]            X,
  input  logic [(DEGREE+1)*WIDTH-1:0] coef,
  output logic                        busy,
  output logic                        pronto,
  output logic                        overflow,
  output logic [WIDTH-1:0]            resultado
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int KW = (DEGREE > 1) ? $clog2(DEGREE + 1) : 1;
  localparam int TW = 2 * WIDTH + 1;
  localparam logic [KW-1:0] K_INIT =
    KW'((DEGREE > 0) ? DEGREE - 1 : 0);

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_c [DEGREE+1];
  logic [KW-1:0]    r_k;
  logic             r_ovf;

  logic [TW-1:0]    w_a;
  logic [TW-1:0]    w_xe;
  logic [TW-1:0]    w_ce;
  logic [TW-1:0]    w_t;
  logic [WIDTH-1:0] w_ck;
  logic [WIDTH-1:0] w_red;
  logic             w_oor;
  logic             w_start;
  logic             w_last;

  assign w_ck    = r_c[r_k];
  assign w_start = (r_state == IDLE) && inicio;
  assign w_last  = (r_k == '0);

  // Operands are extended to 2W+1 bits, so the product
  // and sum are exact for both signed and unsigned cases.
  assign w_t = w_a * w_xe + w_ce;

  if (SIGNED != 0) begin : g_sgn
    assign w_a  = {{(WIDTH+1){r_acc[WIDTH-1]}}, r_acc};
    assign w_xe = {{(WIDTH+1){r_x[WIDTH-1]}}, r_x};
    assign w_ce = {{(WIDTH+1){w_ck[WIDTH-1]}}, w_ck};
    // In range iff bits [2W:W-1] are a pure sign extension.
    assign w_oor = !((&w_t[TW-1:WIDTH-1]) ||
                     !(|w_t[TW-1:WIDTH-1]));
`ifdef POLY_EVAL_SAT_EN
    assign w_red = !w_oor ? w_t[WIDTH-1:0] :
                   w_t[TW-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                               {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign w_red = w_t[WIDTH-1:0];
`endif
  end else begin : g_uns
    assign w_a   = {{(WIDTH+1){1'b0}}, r_acc};
    assign w_xe  = {{(WIDTH+1){1'b0}}, r_x};
    assign w_ce  = {{(WIDTH+1){1'b0}}, w_ck};
    assign w_oor = |w_t[TW-1:WIDTH];
`ifdef POLY_EVAL_SAT_EN
    assign w_red = w_oor ? {WIDTH{1'b1}} : w_t[WIDTH-1:0];
`else
    assign w_red = w_t[WIDTH-1:0];
`endif
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (inicio)
              w_next = (DEGREE == 0) ? DONE : CALC;
      CALC: if (w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_x   <= '0;
      r_acc <= '0;
      r_k   <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i <= DEGREE; i++) r_c[i] <= '0;
    end else if (w_start) begin
      r_x   <= X;
      r_acc <= coef[DEGREE*WIDTH +: WIDTH];
      r_k   <= K_INIT;
      r_ovf <= 1'b0;
      for (int i = 0; i <= DEGREE; i++)
        r_c[i] <= coef[i*WIDTH +: WIDTH];
    end else if (r_state == CALC) begin
      r_acc <= w_red;
      if (w_oor)   r_ovf <= 1'b1;
      if (!w_last) r_k   <= r_k - 1'b1;
    end
  end

  assign busy      = (r_state == CALC);
  assign pronto    = (r_state == DONE);
  assign overflow  = r_ovf;
  assign resultado = r_acc;

endmodule

// File: tb/tb_poly_eval_seq.sv
// tb_poly_eval_seq: randomized and directed checks of poly_eval_seq
// against an arithmetic reference model.
module tb_poly_eval_seq;

  logic ck = 1'b0;
  always #5 ck = ~ck;
  logic rst;

  int errs = 0;
  int checks = 0;

  logic u_go, u_busy, u_pr, u_ovf;
  logic [15:0] u_x, u_res;
  logic [47:0] u_cf;
  logic s_go, s_busy, s_pr, s_ovf;
  logic [15:0] s_x, s_res;
  logic [47:0] s_cf;
  logic q_go, q_busy, q_pr, q_ovf;
  logic [15:0] q_x, q_res;
  logic [79:0] q_cf;
  logic z_go, z_busy, z_pr, z_ovf;
  logic [15:0] z_x, z_res, z_cf;

  poly_eval_seq #(.WIDTH(16), .DEGREE(2), .SIGNED(0)) u_dut (
    .ck(ck), .rst(rst), .inicio(u_go), .X(u_x), .coef(u_cf),
    .busy(u_busy), .pronto(u_pr), .overflow(u_ovf), .resultado(u_res));
  poly_eval_seq #(.WIDTH(16), .DEGREE(2), .SIGNED(1)) s_dut (
    .ck(ck), .rst(rst), .inicio(s_go), .X(s_x), .coef(s_cf),
    .busy(s_busy), .pronto(s_pr), .overflow(s_ovf), .resultado(s_res));
  poly_eval_seq #(.WIDTH(16), .DEGREE(4), .SIGNED(0)) q_dut (
    .ck(ck), .rst(rst), .inicio(q_go), .X(q_x), .coef(q_cf),
    .busy(q_busy), .pronto(q_pr), .overflow(q_ovf), .resultado(q_res));
  poly_eval_seq #(.WIDTH(16), .DEGREE(0), .SIGNED(0)) z_dut (
    .ck(ck), .rst(rst), .inicio(z_go), .X(z_x), .coef(z_cf),
    .busy(z_busy), .pronto(z_pr), .overflow(z_ovf), .resultado(z_res));

  function automatic longint val(input bit sgn, input logic [15:0] v);
    if (sgn) return longint'($signed(v));
    return longint'({48'd0, v});
  endfunction

  // Exact Horner evaluation; each step reduced back to 16 bits.
  function automatic void model(input bit sgn, input int n,
      input logic [15:0] x, input logic [255:0] cf,
      output logic [15:0] res, output bit ovf);
    longint acc, t, lo, hi;
    lo = sgn ? -64'sd32768 : 64'sd0;
    hi = sgn ? 64'sd32767 : 64'sd65535;
    acc = val(sgn, cf[n*16 +: 16]);
    ovf = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      t = acc * val(sgn, x) + val(sgn, cf[i*16 +: 16]);
      if (t < lo || t > hi) begin
        ovf = 1'b1;
`ifdef POLY_EVAL_SAT_EN
        t = (t < lo) ? lo : hi;
`else
        t = t & 64'hFFFF;
        if (sgn && t > 32767) t = t - 65536;
`endif
      end
      acc = t;
    end
    res = acc[15:0];
  endfunction

  task automatic run_u(input logic [15:0] x, input logic [47:0] cf,
                       input string tag);
    logic [15:0] er;
    bit eo;
    int lat;
    model(1'b0, 2, x, 256'(cf), er, eo);
    @(negedge ck);
    u_x = x; u_cf = cf; u_go = 1'b1;
    @(negedge ck);
    u_go = 1'b0;
    u_x = 16'($urandom);
    u_cf = 48'({$urandom(), $urandom()});
    lat = 1;
    while (!u_pr && lat < 20) begin @(negedge ck); lat++; end
    checks++;
    if (lat != 3) begin
      errs++; $display("FAIL %s latency got=%0d exp=3", tag, lat);
    end
    checks++;
    if (u_res !== er) begin
      errs++; $display("FAIL %s result got=%h exp=%h", tag, u_res, er);
    end
    checks++;
    if (u_ovf !== eo) begin
      errs++; $display("FAIL %s ovf got=%b exp=%b", tag, u_ovf, eo);
    end
    @(negedge ck);
    checks++;
    if (u_pr !== 1'b0 || u_res !== er || u_ovf !== eo) begin
      errs++;
      $display("FAIL %s hold pr=%b res=%h ovf=%b exp res=%h ovf=%b",
               tag, u_pr, u_res, u_ovf, er, eo);
    end
  endtask

  task automatic run_s(input logic [15:0] x, input logic [47:0] cf,
                       input string tag);
    logic [15:0] er;
    bit eo;
    int lat;
    model(1'b1, 2, x, 256'(cf), er, eo);
    @(negedge ck);
    s_x = x; s_cf = cf; s_go = 1'b1;
    @(negedge ck);
    s_go = 1'b0;
    lat = 1;
    while (!s_pr && lat < 20) begin @(negedge ck); lat++; end
    checks++;
    if (lat != 3) begin
      errs++; $display("FAIL %s latency got=%0d exp=3", tag, lat);
    end
    checks++;
    if (s_res !== er || s_ovf !== eo) begin
      errs++;
      $display("FAIL %s got res=%h ovf=%b exp res=%h ovf=%b",
               tag, s_res, s_ovf, er, eo);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    u_go = 0; s_go = 0; q_go = 0; z_go = 0;
    u_x = 0; s_x = 0; q_x = 0; z_x = 0;
    u_cf = 0; s_cf = 0; q_cf = 0; z_cf = 0;
    #12;
    checks++;
    if ({u_busy, u_pr, u_ovf, u_res} !== 19'd0) begin
      errs++;
      $display("FAIL reset_u got=%h exp=0", {u_busy, u_pr, u_ovf, u_res});
    end
    checks++;
    if ({s_busy, s_pr, s_ovf, s_res, q_busy, q_pr, q_ovf, q_res,
         z_busy, z_pr, z_ovf, z_res} !== 57'd0) begin
      errs++; $display("FAIL reset_others got=nonzero exp=0");
    end
    @(negedge ck);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    run_u(16'd3, {16'd2, 16'd5, 16'd7}, "basic");
    checks++;
    if (u_res !== 16'd40 || u_ovf !== 1'b0) begin
      errs++;
      $display("FAIL basic_const got=%0d ovf=%b exp=40 ovf=0", u_res, u_ovf);
    end
  endtask

  task automatic test_overflow;
    logic [15:0] exp_r;
`ifdef POLY_EVAL_SAT_EN
    exp_r = 16'd65535;
`else
    exp_r = 16'd19072;
`endif
    run_u(16'd300, {16'd1000, 16'd0, 16'd0}, "ovf");
    checks++;
    if (u_res !== exp_r || u_ovf !== 1'b1) begin
      errs++;
      $display("FAIL ovf_const got=%0d ovf=%b exp=%0d ovf=1",
               u_res, u_ovf, exp_r);
    end
  endtask

  task automatic test_signed;
    run_s(16'hFFFE, {16'd1, 16'd0, 16'hFFFB}, "signed");
    checks++;
    if (s_res !== 16'hFFFF || s_ovf !== 1'b0) begin
      errs++;
      $display("FAIL signed_const got=%h ovf=%b exp=ffff ovf=0",
               s_res, s_ovf);
    end
  endtask

  task automatic test_degree;
    int lat, nb;
    @(negedge ck);
    q_x = 16'd2; q_cf = {5{16'd1}}; q_go = 1'b1;
    @(negedge ck);
    q_go = 1'b0;
    lat = 1; nb = 0;
    while (!q_pr && lat < 30) begin
      if (q_busy) nb++;
      @(negedge ck); lat++;
    end
    checks++;
    if (lat != 5 || nb != 4) begin
      errs++;
      $display("FAIL deg4_timing lat=%0d busy=%0d exp lat=5 busy=4", lat, nb);
    end
    checks++;
    if (q_res !== 16'd31 || q_ovf !== 1'b0) begin
      errs++;
      $display("FAIL deg4_result got=%0d ovf=%b exp=31 ovf=0", q_res, q_ovf);
    end
    @(negedge ck);
    z_cf = 16'd9; z_x = 16'($urandom); z_go = 1'b1;
    @(negedge ck);
    z_go = 1'b0;
    checks++;
    if (z_pr !== 1'b1 || z_res !== 16'd9 || z_busy !== 1'b0) begin
      errs++;
      $display("FAIL deg0 got pr=%b res=%0d busy=%b exp pr=1 res=9 busy=0",
               z_pr, z_res, z_busy);
    end
  endtask

  task automatic test_ignore;
    logic [15:0] er;
    bit eo;
    int lat;
    model(1'b0, 2, 16'd7, 256'({16'd3, 16'd4, 16'd5}), er, eo);
    @(negedge ck);
    u_x = 16'd7; u_cf = {16'd3, 16'd4, 16'd5}; u_go = 1'b1;
    @(negedge ck);
    lat = 1;
    while (!u_pr && lat < 20) begin
      u_go = 1'b1;
      u_x = 16'($urandom);
      u_cf = 48'({$urandom(), $urandom()});
      @(negedge ck); lat++;
    end
    checks++;
    if (lat != 3 || u_res !== er || u_ovf !== eo) begin
      errs++;
      $display("FAIL ignore lat=%0d res=%0d ovf=%b exp lat=3 res=%0d ovf=%b",
               lat, u_res, u_ovf, er, eo);
    end
    @(negedge ck);
    u_go = 1'b0;
    checks++;
    if (u_busy !== 1'b0 || u_pr !== 1'b0 || u_res !== er) begin
      errs++;
      $display("FAIL ignore_done busy=%b pr=%b res=%0d exp 0 0 %0d",
               u_busy, u_pr, u_res, er);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge ck);
    u_x = 16'd3; u_cf = {16'd2, 16'd5, 16'd7}; u_go = 1'b1;
    @(negedge ck);
    u_go = 1'b0;
    @(negedge ck);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({u_busy, u_pr, u_ovf, u_res} !== 19'd0) begin
      errs++;
      $display("FAIL reset_mid got=%h exp=0", {u_busy, u_pr, u_ovf, u_res});
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ck);
      if (u_pr) seen++;
    end
    checks++;
    if (seen != 0) begin
      errs++; $display("FAIL reset_mid_pronto got=%0d exp=0", seen);
    end
    rst = 1'b1;
    run_u(16'd5, {16'd4, 16'd3, 16'd2}, "after_reset");
  endtask

  task automatic test_back_to_back;
    int cyc, np, p0, p1;
    @(negedge ck);
    u_x = 16'd300; u_cf = {16'd1000, 16'd0, 16'd0}; u_go = 1'b1;
    cyc = 0; np = 0; p0 = 0; p1 = 0;
    while (np < 2 && cyc < 40) begin
      @(negedge ck); cyc++;
      if (u_pr) begin
        np++;
        if (np == 1) begin
          p0 = cyc;
          checks++;
          if (u_ovf !== 1'b1) begin
            errs++; $display("FAIL b2b_first_ovf got=%b exp=1", u_ovf);
          end
          u_x = 16'd3; u_cf = {16'd2, 16'd5, 16'd7};
        end else begin
          p1 = cyc;
          checks++;
          if (u_res !== 16'd40 || u_ovf !== 1'b0) begin
            errs++;
            $display("FAIL b2b_second got=%0d ovf=%b exp=40 ovf=0",
                     u_res, u_ovf);
          end
        end
      end
    end
    u_go = 1'b0;
    checks++;
    if (np != 2 || p1 - p0 != 4) begin
      errs++;
      $display("FAIL b2b_period prontos=%0d period=%0d exp 2 and 4",
               np, p1 - p0);
    end
    repeat (6) @(negedge ck);
  endtask

  task automatic test_random;
    logic [15:0] x;
    logic [47:0] cf;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        x = 16'($urandom_range(0, 40));
        cf = {16'($urandom_range(0, 40)), 16'($urandom_range(0, 999)),
              16'($urandom)};
      end else begin
        x = 16'($urandom);
        cf = 48'({$urandom(), $urandom()});
      end
      run_u(x, cf, "rand_u");
      x = (i % 2 == 0) ? 16'($signed(6'($urandom))) : 16'($urandom);
      cf = 48'({$urandom(), $urandom()});
      if (i % 2 == 0)
        cf[47:16] = {16'($signed(5'($urandom))), 16'($signed(8'($urandom)))};
      run_s(x, cf, "rand_s");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_signed;
    test_degree;
    test_ignore;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
